// File: rtl/vector_alu_pipe.sv
// Two-stage SIMD ALU pipeline with valid/ready handshake on both sides.
// Optional signed saturation for add/sub is enabled by defining VECTOR_ALU_SAT_EN.
module vector_alu_pipe #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LANES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    input  logic [2:0]               sel,
    input  logic [LANES-1:0]         mask,
    input  logic                     sat,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   result,
    output logic [4*LANES-1:0]       flags
);

    localparam int unsigned ShW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        OpAdd   = 3'b000,
        OpSub   = 3'b001,
        OpAnd   = 3'b010,
        OpOr    = 3'b011,
        OpXor   = 3'b100,
        OpShl   = 3'b101,
        OpPassA = 3'b110,
        OpPassB = 3'b111
    } op_e;

    logic                   s1_valid_q, s1_valid_d;
    logic [LANES*WIDTH-1:0] a_q, a_d;
    logic [LANES*WIDTH-1:0] b_q, b_d;
    op_e                    sel_q, sel_d;
    logic [LANES-1:0]       mask_q, mask_d;
    logic                   s2_valid_q, s2_valid_d;
    logic [LANES*WIDTH-1:0] result_q, result_d;
    logic [4*LANES-1:0]     flags_q, flags_d;
    logic                   s2_adv;
    logic [LANES*WIDTH-1:0] lane_res;
    logic [4*LANES-1:0]     lane_flags;

`ifdef VECTOR_ALU_SAT_EN
    localparam logic [WIDTH-1:0] MaxPos = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MinNeg = {1'b1, {(WIDTH-1){1'b0}}};
    logic sat_q, sat_d;
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

    // Handshake: S2 drains or is empty, and S1 moves whenever S2 moves.
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        in_ready   = !s1_valid_q || s2_adv;
        s1_valid_d = s1_valid_q;
        a_d        = a_q;
        b_d        = b_q;
        sel_d      = sel_q;
        mask_d     = mask_q;
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        flags_d    = flags_q;
`ifdef VECTOR_ALU_SAT_EN
        sat_d      = sat_q;
`endif
        if (in_ready) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                a_d    = a;
                b_d    = b;
                sel_d  = op_e'(sel);
                mask_d = mask;
`ifdef VECTOR_ALU_SAT_EN
                sat_d  = sat;
`endif
            end
        end
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = lane_res;
                flags_d  = lane_flags;
            end
        end
    end

    always_comb begin
        logic [WIDTH-1:0] op_a;
        logic [WIDTH-1:0] op_b;
        logic [WIDTH-1:0] res;
        logic [WIDTH:0]   ext;
        logic             c;
        logic             v;
        lane_res   = '0;
        lane_flags = '0;
        for (int i = 0; i < LANES; i++) begin
            op_a = a_q[i*WIDTH +: WIDTH];
            op_b = b_q[i*WIDTH +: WIDTH];
            ext  = '0;
            res  = '0;
            c    = 1'b0;
            v    = 1'b0;
            case (sel_q)
                OpAdd: begin
                    ext = {1'b0, op_a} + {1'b0, op_b};
                    res = ext[WIDTH-1:0];
                    c   = ext[WIDTH];
                    v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OpSub: begin
                    ext = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
                    res = ext[WIDTH-1:0];
                    c   = ext[WIDTH];
                    v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (res[WIDTH-1] != op_a[WIDTH-1]);
                end
                OpAnd:   res = op_a & op_b;
                OpOr:    res = op_a | op_b;
                OpXor:   res = op_a ^ op_b;
                OpShl: begin
                    // Bit WIDTH of the widened shift is the last bit pushed out.
                    ext = {1'b0, op_a} << op_b[ShW-1:0];
                    res = ext[WIDTH-1:0];
                    c   = ext[WIDTH];
                end
                OpPassA: res = op_a;
                default: res = op_b;
            endcase
`ifdef VECTOR_ALU_SAT_EN
            // Overflow direction always follows the sign of A for both add and sub.
            if (sat_q && v && (sel_q == OpAdd || sel_q == OpSub)) begin
                res = op_a[WIDTH-1] ? MinNeg : MaxPos;
            end
`endif
            if (mask_q[i]) begin
                lane_res[i*WIDTH +: WIDTH] = res;
                lane_flags[4*i +: 4]       = {res[WIDTH-1], res == '0, v, c};
            end else begin
                lane_res[i*WIDTH +: WIDTH] = op_a;
                lane_flags[4*i +: 4]       = 4'b0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            sel_q      <= OpAdd;
            mask_q     <= '0;
            s2_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
`ifdef VECTOR_ALU_SAT_EN
            sat_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sel_q      <= sel_d;
            mask_q     <= mask_d;
            s2_valid_q <= s2_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
`ifdef VECTOR_ALU_SAT_EN
            sat_q      <= sat_d;
`endif
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_vector_alu_pipe.sv
// Directed self-checking bench for vector_alu_pipe (WIDTH=16, LANES=4).
// Expectations follow VECTOR_ALU_SAT_EN when the bench is built with it.
module tb_vector_alu_pipe;

    localparam int unsigned W = 16;
    localparam int unsigned L = 4;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [L*W-1:0] a;
    logic [L*W-1:0] b;
    logic [2:0]     sel;
    logic [L-1:0]   mask;
    logic           sat;
    logic           out_valid;
    logic           out_ready;
    logic [L*W-1:0] result;
    logic [4*L-1:0] flags;

    int n_checks = 0;
    int n_pass   = 0;

    vector_alu_pipe #(
        .WIDTH (W),
        .LANES (L)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sel       (sel),
        .mask      (mask),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Called just after a rising edge with an empty pipeline.
    task automatic run_vec(input string tag, input logic [63:0] va, input logic [63:0] vb,
                           input logic [2:0] vsel, input logic [3:0] vmask, input logic vsat,
                           input logic [63:0] exp_res, input logic [15:0] exp_flags);
        a         = va;
        b         = vb;
        sel       = vsel;
        mask      = vmask;
        sat       = vsat;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check({tag, "_lat1_valid"}, 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_result"}, result, exp_res);
        check({tag, "_flags"}, 64'(flags), 64'(exp_flags));
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] stream_exp(input int idx);
        logic [15:0] v;
        v = 16'((idx + 1) * 16'h0101 + 1);
        return {4{v}};
    endfunction

    initial begin
        int  sent;
        int  got;
        bit  dropped;
        bit  in_fire;
        bit  out_fire;
        logic [15:0] sv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        sel       = 3'b000;
        mask      = 4'hF;
        sat       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_result", result, 64'd0);
        check("rst_flags", 64'(flags), 64'd0);
        rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Add: wrap to zero, carry, both overflow directions.
        run_vec("add", {16'h7FFF, 16'h1234, 16'h8000, 16'hFFFF},
                {16'h0001, 16'h1111, 16'h8000, 16'h0001}, 3'b000, 4'hF, 1'b0,
                {16'h8000, 16'h2345, 16'h0000, 16'h0000}, 16'hA075);

`ifdef VECTOR_ALU_SAT_EN
        run_vec("sub_sat", {16'h1234, 16'h7FFF, 16'h0005, 16'h8000},
                {16'h1234, 16'hFFFF, 16'h0007, 16'h0001}, 3'b001, 4'hF, 1'b1,
                {16'h0000, 16'h7FFF, 16'hFFFE, 16'h8000}, 16'h528B);
`else
        run_vec("sub_sat", {16'h1234, 16'h7FFF, 16'h0005, 16'h8000},
                {16'h1234, 16'hFFFF, 16'h0007, 16'h0001}, 3'b001, 4'hF, 1'b1,
                {16'h0000, 16'h8000, 16'hFFFE, 16'h7FFF}, 16'h5A83);
`endif

        run_vec("shl", {16'h0003, 16'h8001, 16'h00FF, 16'hC001},
                {16'h000F, 16'h0010, 16'h0000, 16'h0001}, 3'b101, 4'hF, 1'b0,
                {16'h8000, 16'h8001, 16'h00FF, 16'h8002}, 16'h9809);
        run_vec("shl_mask", {16'h0003, 16'h8001, 16'h00FF, 16'hC001},
                {16'h000F, 16'h0010, 16'h0000, 16'h0001}, 3'b101, 4'b1110, 1'b0,
                {16'h8000, 16'h8001, 16'h00FF, 16'hC001}, 16'h9800);

        run_vec("and", {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234},
                {16'hFF00, 16'h0000, 16'h5555, 16'h00FF}, 3'b010, 4'hF, 1'b0,
                {16'hF000, 16'h0000, 16'h0000, 16'h0034}, 16'h8440);
        run_vec("or", {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234},
                {16'hFF00, 16'h0000, 16'h5555, 16'h00FF}, 3'b011, 4'hF, 1'b0,
                {16'hFFF0, 16'h0000, 16'hFFFF, 16'h12FF}, 16'h8480);
        run_vec("xor", {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234},
                {16'hFF00, 16'h0000, 16'h5555, 16'h00FF}, 3'b100, 4'hF, 1'b0,
                {16'h0FF0, 16'h0000, 16'hFFFF, 16'h12CB}, 16'h0480);
        run_vec("pass_a", {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234},
                {16'hFF00, 16'h0000, 16'h5555, 16'h00FF}, 3'b110, 4'hF, 1'b0,
                {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234}, 16'h8480);
        run_vec("pass_b_mask", {16'hF0F0, 16'h0000, 16'hAAAA, 16'h1234},
                {16'hFF00, 16'h0000, 16'h5555, 16'h00FF}, 3'b111, 4'b0101, 1'b0,
                {16'hF0F0, 16'h0000, 16'hAAAA, 16'h00FF}, 16'h0400);

        // Back-to-back stream with a three-cycle consumer stall.
        sent    = 0;
        got     = 0;
        dropped = 1'b0;
        b       = {4{16'h0001}};
        sel     = 3'b000;
        mask    = 4'hF;
        sat     = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = (sent < 6);
            sv        = 16'((sent + 1) * 16'h0101);
            a         = {4{sv}};
            #1;
            if (!in_ready) dropped = 1'b1;
            if (cyc >= 3 && cyc <= 5) check("stall_valid", 64'(out_valid), 64'd1);
            if (out_valid) check("stream_result", result, stream_exp(got));
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            @(posedge clk);
            #1;
            if (in_fire) sent++;
            if (out_fire) got++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_delivered", 64'(got), 64'd6);
        check("stream_in_ready_drop", 64'(dropped), 64'd1);
        #1;
        check("stream_drained", 64'(out_valid), 64'd0);

        // Reset while stalled with both stages full.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a         = {4{16'h5555}};
        sel       = 3'b110;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        check("stall_rst_valid", 64'(out_valid), 64'd0);
        check("stall_rst_result", result, 64'd0);
        check("stall_rst_flags", 64'(flags), 64'd0);
        check("stall_rst_in_ready", 64'(in_ready), 64'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("post_rst_discard", 64'(out_valid), 64'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/vector_alu_pipe.md
VECTOR_ALU_PIPE -- requirements
Module: vector_alu_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, lane data width in bits (legal 8..64, power of two).
REQ-002 SHALL have parameter LANES, default 4, number of independent SIMD lanes (legal 1..16).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand bundle present.
REQ-006 SHALL have port in_ready  output  1  block accepts bundle this cycle.
REQ-007 SHALL have port a  input  LANES*WIDTH  lane operands A, lane i at bits [i*WIDTH +: WIDTH].
REQ-008 SHALL have port b  input  LANES*WIDTH  lane operands B, same packing.
REQ-009 SHALL have port sel  input  3  opcode, shared by all lanes.
REQ-010 SHALL have port mask  input  LANES  per-lane enable; 0 = lane passes A, flags cleared.
REQ-011 SHALL have port sat  input  1  saturating add/sub request (effective only per REQ-032).
REQ-012 SHALL have port out_valid  output  1  result bundle present.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port result  output  LANES*WIDTH  lane results, same packing.
REQ-015 SHALL have port flags  output  4*LANES  per-lane {N,Z,V,C}, lane i at bits [4*i +: 4].

Function
REQ-016 Opcodes SHALL be: 000 add, 001 sub (A-B), 010 and, 011 or, 100 xor, 101 shift left A by B[log2(WIDTH)-1:0], 110 pass A, 111 pass B.
REQ-017 Add: C = carry out of bit WIDTH-1; V = signed overflow.
REQ-018 Sub: computed as A + ~B + 1; C = carry out (1 means no borrow); V = signed overflow.
REQ-019 Shift: C = last bit shifted out (0 for shift amount 0); V = 0.
REQ-020 Logic and pass opcodes: C = 0, V = 0.
REQ-021 N SHALL equal result MSB; Z SHALL be 1 iff lane result is all zeros; both derived from the final (post-saturation) lane result.
REQ-022 Masked lane (mask[i]=0): result lane = A lane, flags lane = 4'b0000.
REQ-023 Pipeline SHALL be two registered stages: S1 captures operands/opcode/mask/sat; S2 captures lane results and flags.
REQ-024 Transfer on input SHALL occur iff in_valid && in_ready; on output iff out_valid && out_ready.
REQ-025 Latency SHALL be exactly 2 cycles from input transfer to out_valid with no back-pressure; throughput one bundle per cycle.
REQ-026 S2 SHALL load when S2 empty or out_ready=1; S1 SHALL advance under the same condition.
REQ-027 in_ready SHALL be 1 when S1 empty or S1 can advance this cycle (combinational from out_ready and stage valids).
REQ-028 While out_valid=1 and out_ready=0, result and flags SHALL hold stable; no bundle SHALL be dropped or duplicated.
REQ-029 Simultaneous input and output transfer with both stages full SHALL shift the pipeline with no bubble.
REQ-030 Bundles SHALL emerge in acceptance order.

Reset
REQ-031 When rst_n=0 at a rising edge: both stage valids clear, out_valid=0, result=0, flags=0; in_ready=1 in the first cycle after reset; in-flight bundles discarded, including mid-stall.

Configuration
REQ-032 Macro VECTOR_ALU_SAT_EN: when defined, add/sub with sat=1 SHALL clamp signed overflow to 0x7FFF.. / 0x8000.. (WIDTH-scaled) and report V=1, C unchanged from REQ-017/018; when undefined, the sat port SHALL be ignored and add/sub wrap.

Verification
REQ-033 WIDTH=16, LANES=4, sel=000, a lane0=0xFFFF, b lane0=0x0001, mask=4'hF -> after 2 cycles result lane0=0x0000, flags lane0 N=0 Z=1 V=0 C=1.
REQ-034 sel=001, a=0x8000, b=0x0001, sat=1 -> with VECTOR_ALU_SAT_EN: result 0x8000, V=1, C=1; without: result 0x7FFF, V=1, C=1.
REQ-035 sel=101, a=0xC001, b=0x0001 -> result 0x8002, N=1, C=1, V=0; mask=4'b1110 on same bundle -> lane0 result 0xC001, flags 0.
REQ-036 Stream 6 bundles back-to-back, out_ready=0 for cycles 3-5 -> in_ready drops once both stages full, results held stable, all 6 delivered in order, none lost.
REQ-037 Assert rst_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, result=0, flags=0, in_ready=1.
